// File: rtl/pipelined_controller.sv
// Control unit for a 5-stage RV32I pipeline: decodes the instruction in ID and carries the
// control word through ID/EX, EX/MEM and MEM/WB. Branches and jumps are resolved in EX.
module pipelined_controller #(
  parameter int unsigned ALU_CTRL_W   = 3,
  parameter int unsigned IMM_SRC_W    = 2,
  parameter int unsigned SUPPORT_JALR = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [6:0]            op_d,
  input  logic [2:0]            funct3_d,
  input  logic                  funct7b5_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic                  zero_e,
  input  logic                  neg_e,
  input  logic                  carry_e,
  input  logic                  ovf_e,
  output logic [IMM_SRC_W-1:0]  imm_src_d,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic                  alu_src_e,
  output logic                  jalr_e,
  output logic                  pc_src_e,
  output logic [1:0]            result_src_e,
  output logic                  illegal_e,
  output logic                  mem_write_m,
  output logic                  reg_write_m,
  output logic [1:0]            result_src_m,
  output logic                  reg_write_w,
  output logic [1:0]            result_src_w
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  alu_src;
    logic                  jalr;
    logic                  illegal;
    logic [2:0]            funct3;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_w_t;

  ctrl_e_t    dec_d;
  ctrl_e_t    ex_d, ex_q;
  ctrl_m_t    mem_d, mem_q;
  ctrl_w_t    wb_d, wb_q;
  logic [3:0] alu_arith;
  logic [3:0] alu_d;
  logic [2:0] imm_d;
  logic       legal;
  logic       taken;

  // Arithmetic op code from funct3; sub only for R-type (op bit 5 separates R from I-ALU).
  always_comb begin
    alu_arith = 4'd0;
    case (funct3_d)
      3'b000:  alu_arith = (funct7b5_d & op_d[5]) ? 4'd1 : 4'd0;
      3'b001:  alu_arith = 4'd7;
      3'b010:  alu_arith = 4'd5;
      3'b011:  alu_arith = 4'd6;
      3'b100:  alu_arith = 4'd4;
      3'b101:  alu_arith = funct7b5_d ? 4'd9 : 4'd8;
      3'b110:  alu_arith = 4'd3;
      default: alu_arith = 4'd2;
    endcase
  end

  // Main decode; anything undecodable collapses to a word carrying only the illegal flag.
  always_comb begin
    dec_d = '0;
    imm_d = 3'd0;
    alu_d = 4'd0;
    legal = 1'b1;
    case (op_d)
      OP_LW: begin
        dec_d.reg_write  = 1'b1;
        dec_d.result_src = 2'b01;
        dec_d.alu_src    = 1'b1;
      end
      OP_SW: begin
        dec_d.mem_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        imm_d           = 3'd1;
      end
      OP_R: begin
        dec_d.reg_write = 1'b1;
        alu_d           = alu_arith;
      end
      OP_I: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src   = 1'b1;
        alu_d           = alu_arith;
      end
      OP_B: begin
        dec_d.branch = 1'b1;
        imm_d        = 3'd2;
        alu_d        = 4'd1;
        legal        = (funct3_d[2:1] != 2'b01);
      end
      OP_JAL: begin
        dec_d.jump       = 1'b1;
        dec_d.reg_write  = 1'b1;
        dec_d.result_src = 2'b10;
        imm_d            = 3'd3;
      end
      OP_JALR: begin
        if (SUPPORT_JALR != 0) begin
          dec_d.jump       = 1'b1;
          dec_d.jalr       = 1'b1;
          dec_d.reg_write  = 1'b1;
          dec_d.result_src = 2'b10;
          dec_d.alu_src    = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_LUI: begin
        if (IMM_SRC_W >= 3) begin
          dec_d.reg_write  = 1'b1;
          dec_d.result_src = 2'b11;
          dec_d.alu_src    = 1'b1;
          imm_d            = 3'd4;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (32'(alu_d) >= (32'd1 << ALU_CTRL_W)) legal = 1'b0;
    dec_d.alu_control = ALU_CTRL_W'(alu_d);
    dec_d.funct3      = funct3_d;
    if (!legal) begin
      dec_d         = '0;
      dec_d.illegal = 1'b1;
      imm_d         = 3'd0;
    end
  end

  assign imm_src_d = IMM_SRC_W'(imm_d);

  // Next-state of the pipeline registers; flush beats stall, later stages always advance.
  always_comb begin
    ex_d = ex_q;
    if (flush_e) begin
      ex_d = '0;
    end else if (!stall_e) begin
      ex_d = dec_d;
    end
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.result_src = ex_q.result_src;
    mem_d.mem_write  = ex_q.mem_write;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.result_src  = mem_q.result_src;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Branch condition from full ALU flags; carry means no borrow on a-b.
  always_comb begin
    taken = 1'b0;
    case (ex_q.funct3)
      3'b000:  taken = zero_e;
      3'b001:  taken = ~zero_e;
      3'b100:  taken = neg_e ^ ovf_e;
      3'b101:  taken = ~(neg_e ^ ovf_e);
      3'b110:  taken = ~carry_e;
      3'b111:  taken = carry_e;
      default: taken = 1'b0;
    endcase
  end

  assign pc_src_e      = ex_q.jump | (ex_q.branch & taken);
  assign alu_control_e = ex_q.alu_control;
  assign alu_src_e     = ex_q.alu_src;
  assign jalr_e        = ex_q.jalr;
  assign result_src_e  = ex_q.result_src;
  assign illegal_e     = ex_q.illegal;
  assign mem_write_m   = mem_q.mem_write;
  assign reg_write_m   = mem_q.reg_write;
  assign result_src_m  = mem_q.result_src;
  assign reg_write_w   = wb_q.reg_write;
  assign result_src_w  = wb_q.result_src;

endmodule

// File: tb/tb_pipelined_controller.sv
// Scoreboard bench for pipelined_controller: two configurations (narrow default, wide without jalr)
// share one stimulus stream; expectations come from an instruction-level pipeline model.
module tb_pipelined_controller;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] op_d = '0;
  logic [2:0] funct3_d = '0;
  logic funct7b5_d = 1'b0, stall_e = 1'b0, flush_e = 1'b0;
  logic zero_e = 1'b0, neg_e = 1'b0, carry_e = 1'b0, ovf_e = 1'b0;

  logic [1:0] imm0;  logic [2:0] alu0;  logic asrc0, jalr0, pc0, ill0, mw_m0, rw_m0, rw_w0;
  logic [1:0] rs_e0, rs_m0, rs_w0;
  logic [2:0] imm1;  logic [3:0] alu1;  logic asrc1, jalr1, pc1, ill1, mw_m1, rw_m1, rw_w1;
  logic [1:0] rs_e1, rs_m1, rs_w1;

  pipelined_controller dut0 (
    .clk(clk), .reset_n(reset_n), .op_d(op_d), .funct3_d(funct3_d), .funct7b5_d(funct7b5_d),
    .stall_e(stall_e), .flush_e(flush_e), .zero_e(zero_e), .neg_e(neg_e), .carry_e(carry_e),
    .ovf_e(ovf_e), .imm_src_d(imm0), .alu_control_e(alu0), .alu_src_e(asrc0), .jalr_e(jalr0),
    .pc_src_e(pc0), .result_src_e(rs_e0), .illegal_e(ill0), .mem_write_m(mw_m0),
    .reg_write_m(rw_m0), .result_src_m(rs_m0), .reg_write_w(rw_w0), .result_src_w(rs_w0));

  pipelined_controller #(.ALU_CTRL_W(4), .IMM_SRC_W(3), .SUPPORT_JALR(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .op_d(op_d), .funct3_d(funct3_d), .funct7b5_d(funct7b5_d),
    .stall_e(stall_e), .flush_e(flush_e), .zero_e(zero_e), .neg_e(neg_e), .carry_e(carry_e),
    .ovf_e(ovf_e), .imm_src_d(imm1), .alu_control_e(alu1), .alu_src_e(asrc1), .jalr_e(jalr1),
    .pc_src_e(pc1), .result_src_e(rs_e1), .illegal_e(ill1), .mem_write_m(mw_m1),
    .reg_write_m(rw_m1), .result_src_m(rs_m1), .reg_write_w(rw_w1), .result_src_w(rs_w1));

  typedef struct {
    int rw, rs, mw, jump, branch, alu, asrc, jalr, ill, imm, f3;
  } ctl_t;

  typedef struct {
    int imm, alu, asrc, jalr, pc, rs_e, ill, mw_m, rw_m, rs_m, rw_w, rs_w;
  } obs_t;

  int n_tests = 0;
  int n_fail  = 0;
  obs_t q0[$];
  obs_t q1[$];

  ctl_t ex_m [2];
  int mem_rw [2], mem_rs [2], mem_mw [2], wb_rw [2], wb_rs [2];

  bit [6:0] p_op;
  bit [2:0] p_f3;
  bit p_f7, p_st, p_fl;
  bit p_rst = 1'b1;

  function automatic int aw(int k); return (k == 0) ? 3 : 4; endfunction
  function automatic int iw(int k); return (k == 0) ? 2 : 3; endfunction
  function automatic bit jok(int k); return (k == 0); endfunction

  function automatic int alu_code(bit [2:0] f3, bit f7, bit is_r);
    case (f3)
      3'd0: return (is_r && f7) ? 1 : 0;
      3'd1: return 7;
      3'd2: return 5;
      3'd3: return 6;
      3'd4: return 4;
      3'd5: return f7 ? 9 : 8;
      3'd6: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic ctl_t decode(bit [6:0] op, bit [2:0] f3, bit f7, int k);
    ctl_t c;
    bit ok;
    c = '{default: 0};
    ok = 1'b1;
    c.f3 = int'(f3);
    case (op)
      OP_LW:  begin c.rw = 1; c.rs = 1; c.asrc = 1; end
      OP_SW:  begin c.mw = 1; c.asrc = 1; c.imm = 1; end
      OP_R:   begin c.rw = 1; c.alu = alu_code(f3, f7, 1'b1); end
      OP_I:   begin c.rw = 1; c.asrc = 1; c.alu = alu_code(f3, f7, 1'b0); end
      OP_B:   begin c.branch = 1; c.imm = 2; c.alu = 1; ok = !(f3 == 3'd2 || f3 == 3'd3); end
      OP_JAL: begin c.jump = 1; c.rw = 1; c.rs = 2; c.imm = 3; end
      OP_JALR:
        if (jok(k)) begin c.jump = 1; c.jalr = 1; c.rw = 1; c.rs = 2; c.asrc = 1; end
        else ok = 1'b0;
      OP_LUI:
        if (iw(k) >= 3) begin c.rw = 1; c.rs = 3; c.asrc = 1; c.imm = 4; end
        else ok = 1'b0;
      default: ok = 1'b0;
    endcase
    if (c.alu >= (1 << aw(k))) ok = 1'b0;
    if (!ok) begin
      c = '{default: 0};
      c.ill = 1;
    end
    return c;
  endfunction

  function automatic int taken(int f3, bit z, bit n, bit c, bit v);
    case (f3)
      0: return int'(z);
      1: return int'(!z);
      4: return int'(n ^ v);
      5: return int'(!(n ^ v));
      6: return int'(!c);
      7: return int'(c);
      default: return 0;
    endcase
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      ex_m[k] = '{default: 0};
      mem_rw[k] = 0; mem_rs[k] = 0; mem_mw[k] = 0; wb_rw[k] = 0; wb_rs[k] = 0;
    end
  endtask

  // One clock cycle: retire the previous edge into the model, drive new inputs, queue expectations.
  task automatic cycle(input bit [6:0] op, input bit [2:0] f3, input bit f7, input bit st,
                       input bit fl, input bit z, input bit n, input bit c, input bit v,
                       input bit rst);
    obs_t e;
    @(negedge clk);
    if (p_rst) begin
      clear_model();
    end else begin
      for (int k = 0; k < 2; k++) begin
        wb_rw[k] = mem_rw[k]; wb_rs[k] = mem_rs[k];
        mem_rw[k] = ex_m[k].rw; mem_rs[k] = ex_m[k].rs; mem_mw[k] = ex_m[k].mw;
        if (p_fl) ex_m[k] = '{default: 0};
        else if (!p_st) ex_m[k] = decode(p_op, p_f3, p_f7, k);
      end
    end
    op_d = op; funct3_d = f3; funct7b5_d = f7; stall_e = st; flush_e = fl;
    zero_e = z; neg_e = n; carry_e = c; ovf_e = v;
    reset_n = !rst;
    if (rst) clear_model();
    p_op = op; p_f3 = f3; p_f7 = f7; p_st = st; p_fl = fl; p_rst = rst;
    for (int k = 0; k < 2; k++) begin
      e.imm  = decode(op, f3, f7, k).imm;
      e.alu  = ex_m[k].alu;
      e.asrc = ex_m[k].asrc;
      e.jalr = ex_m[k].jalr;
      e.pc   = (ex_m[k].jump != 0 || (ex_m[k].branch != 0 && taken(ex_m[k].f3, z, n, c, v) != 0)) ? 1 : 0;
      e.rs_e = ex_m[k].rs;
      e.ill  = ex_m[k].ill;
      e.mw_m = mem_mw[k]; e.rw_m = mem_rw[k]; e.rs_m = mem_rs[k];
      e.rw_w = wb_rw[k];  e.rs_w = wb_rs[k];
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input int k, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s cfg%0d @%0t: got %0d expected %0d", nm, k, $time, act, exp_v);
    end
  endtask

  task automatic compare(input int k, input obs_t e);
    obs_t a;
    if (k == 0) begin
      a.imm = int'(imm0); a.alu = int'(alu0); a.asrc = int'(asrc0); a.jalr = int'(jalr0);
      a.pc = int'(pc0); a.rs_e = int'(rs_e0); a.ill = int'(ill0); a.mw_m = int'(mw_m0);
      a.rw_m = int'(rw_m0); a.rs_m = int'(rs_m0); a.rw_w = int'(rw_w0); a.rs_w = int'(rs_w0);
    end else begin
      a.imm = int'(imm1); a.alu = int'(alu1); a.asrc = int'(asrc1); a.jalr = int'(jalr1);
      a.pc = int'(pc1); a.rs_e = int'(rs_e1); a.ill = int'(ill1); a.mw_m = int'(mw_m1);
      a.rw_m = int'(rw_m1); a.rs_m = int'(rs_m1); a.rw_w = int'(rw_w1); a.rs_w = int'(rs_w1);
    end
    chk("imm_src_d", k, a.imm, e.imm);
    chk("alu_control_e", k, a.alu, e.alu);
    chk("alu_src_e", k, a.asrc, e.asrc);
    chk("jalr_e", k, a.jalr, e.jalr);
    chk("pc_src_e", k, a.pc, e.pc);
    chk("result_src_e", k, a.rs_e, e.rs_e);
    chk("illegal_e", k, a.ill, e.ill);
    chk("mem_write_m", k, a.mw_m, e.mw_m);
    chk("reg_write_m", k, a.rw_m, e.rw_m);
    chk("result_src_m", k, a.rs_m, e.rs_m);
    chk("reg_write_w", k, a.rw_w, e.rw_w);
    chk("result_src_w", k, a.rs_w, e.rs_w);
  endtask

  // Monitor: inputs settle at the falling edge, outputs are sampled 3 time units later.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q0.size() > 0) begin e = q0.pop_front(); compare(0, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); compare(1, e); end
    end
  end

  initial begin
    bit [6:0] ops [9];
    bit [6:0] op;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_BAD};
    clear_model();

    cycle(OP_I, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(OP_I, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // sub through all stages
    cycle(OP_R, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle(OP_I, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // beq taken / not taken
    cycle(OP_B, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(OP_B, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cycle(OP_B, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    // blt with N=V, then blt with N!=V, then bgeu with carry
    cycle(OP_B, 4, 0, 0, 0, 0, 1, 0, 1, 0);
    cycle(OP_B, 7, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle(OP_I, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // lw held by stall, then stall+flush gives a bubble
    cycle(OP_LW, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle(OP_R, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cycle(OP_R, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cycle(OP_I, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // illegal opcode and illegal branch funct3 with flags that would otherwise take
    cycle(OP_BAD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(OP_B, 2, 0, 0, 0, 1, 1, 1, 0, 0);
    cycle(OP_I, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    // srai and lui (wide config)
    cycle(OP_I, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(OP_LUI, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle(OP_I, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // async reset with a store in MEM
    cycle(OP_SW, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(OP_I, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(OP_I, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(OP_JAL, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      cycle(op, 3'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 59) == 0);
    end
    cycle(OP_I, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #5;
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q0.size() + q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
